input_conditioner: RTL and testbench

//   Front-end for the safe's push-button/switch inputs (a, b, lock, open, doorCls).

---
 rtl/input_conditioner.sv | 151 +++++++++++++++
 tb/tb_input_conditioner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces (on tick_1ms) and edge-detects the safe's
// button/switch pins, with optional auto-repeat rise pulses on held channels.
module input_conditioner #(
  parameter int                N_IN       = 5,
  parameter int                DEB_TICKS  = 20,
  parameter int                REP_DELAY  = 500,
  parameter int                REP_PERIOD = 150,
  parameter logic [N_IN-1:0]   REP_MASK   = 5'b00011
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_1ms,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] level,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall
);

  localparam int MAX_CNT = (DEB_TICKS > (REP_DELAY + REP_PERIOD)) ? DEB_TICKS
                                                                   : (REP_DELAY + REP_PERIOD);
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEB_TICKS);
  localparam logic [CNT_W-1:0] REP_D_C = CNT_W'(REP_DELAY);
  localparam logic [CNT_W-1:0] REP_W_C = CNT_W'(REP_DELAY + REP_PERIOD);

  localparam logic [1:0] S_LO = 2'd0;
  localparam logic [1:0] S_PH = 2'd1;
  localparam logic [1:0] S_HI = 2'd2;
  localparam logic [1:0] S_PL = 2'd3;

  logic [N_IN-1:0] sync1_q;
  logic [N_IN-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] rcnt_q, rcnt_d, rcnt_inc;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             s;

    assign s        = sync2_q[g];
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign rcnt_inc = rcnt_q + CNT_W'(1);

    // State only moves on tick edges; pulses default low so they last a single clk.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (tick_1ms) begin
        case (state_q)
          S_LO: begin
            if (s) begin
              state_d = S_PH;
              cnt_d   = CNT_W'(1);
            end
          end
          S_PH: begin
            if (!s) begin
              state_d = S_LO;
              cnt_d   = '0;
            end else if (cnt_inc >= DEB_C) begin
              state_d = S_HI;
              cnt_d   = '0;
              rcnt_d  = '0;
              level_d = 1'b1;
              rise_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          S_HI: begin
            if (!s) begin
              state_d = S_PL;
              cnt_d   = CNT_W'(1);
            end else if (REP_MASK[g]) begin
              // After the initial delay the counter cycles through one repeat period.
              if (rcnt_inc == REP_D_C) begin
                rise_d = 1'b1;
              end
              if (rcnt_inc == REP_W_C) begin
                rise_d = 1'b1;
                rcnt_d = REP_D_C;
              end else begin
                rcnt_d = rcnt_inc;
              end
            end
          end
          S_PL: begin
            if (s) begin
              state_d = S_HI;
              cnt_d   = '0;
            end else if (cnt_inc >= DEB_C) begin
              state_d = S_LO;
              cnt_d   = '0;
              rcnt_d  = '0;
              level_d = 1'b0;
              fall_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: begin
            state_d = S_LO;
            cnt_d   = '0;
            rcnt_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= S_LO;
        cnt_q   <= '0;
        rcnt_q  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rcnt_q  <= rcnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign level[g] = level_q;
    assign rise[g]  = rise_q;
    assign fall[g]  = fall_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEB_TICKS=4, REP_DELAY=10, REP_PERIOD=3 and
// a single-clk tick every 4 clk.
module tb_input_conditioner;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick = 1'b0;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] level;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  int checks   = 0;
  int failures = 0;

  int           rise_cnt [N];
  int           fall_cnt [N];
  int           bad_cnt = 0;
  logic [N-1:0] prev_rise = '0;
  logic [N-1:0] prev_fall = '0;
  int           base_r;
  int           base_f;

  input_conditioner #(
    .N_IN      (5),
    .DEB_TICKS (4),
    .REP_DELAY (10),
    .REP_PERIOD(3),
    .REP_MASK  (5'b00011)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_1ms(tick),
    .raw_in  (raw_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk) tick = 1'b0;
      @(negedge clk) tick = 1'b1;
    end
  end

  // Pulse bookkeeping: counts per channel, plus any rise/fall overlap or multi-clk pulse.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] <= rise_cnt[i] + (rise[i] ? 1 : 0);
      fall_cnt[i] <= fall_cnt[i] + (fall[i] ? 1 : 0);
    end
    if (((rise & fall) != '0) || ((rise & prev_rise) != '0) || ((fall & prev_fall) != '0))
      bad_cnt <= bad_cnt + 1;
    prev_rise <= rise;
    prev_fall <= fall;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check5(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_wait(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (!tick);
    end
    #1;
  endtask

  initial begin
    // Reset state
    clk_wait(3);
    check5("reset_level", level, 5'b00000);
    check5("reset_rise",  rise,  5'b00000);
    check5("reset_fall",  fall,  5'b00000);
    rst = 1'b1;
    clk_wait(10);
    check5("idle_level", level, 5'b00000);

    // Clean press and release on channel 0
    base_r = rise_cnt[0];
    base_f = fall_cnt[0];
    raw_in = 5'b00001;
    clk_wait(2);
    tick_wait(3);
    check5("press0_pre_level", level, 5'b00000);
    tick_wait(1);
    check5("press0_level", level, 5'b00001);
    check5("press0_rise",  rise,  5'b00001);
    clk_wait(1);
    check5("press0_rise_1clk", rise, 5'b00000);
    raw_in = 5'b00000;
    clk_wait(2);
    tick_wait(3);
    check5("rel0_pre_level", level, 5'b00001);
    check5("rel0_pre_fall",  fall,  5'b00000);
    tick_wait(1);
    check5("rel0_level", level, 5'b00000);
    check5("rel0_fall",  fall,  5'b00001);
    clk_wait(2);
    checkn("press0_rise_count", rise_cnt[0] - base_r, 1);
    checkn("press0_fall_count", fall_cnt[0] - base_f, 1);

    // Bounce on channel 2: high 2 ticks, low 1, high 2, low
    base_r = rise_cnt[2];
    base_f = fall_cnt[2];
    raw_in = 5'b00100;
    clk_wait(8);
    raw_in = 5'b00000;
    clk_wait(4);
    raw_in = 5'b00100;
    clk_wait(8);
    check5("bounce_mid_level", level, 5'b00000);
    raw_in = 5'b00000;
    tick_wait(8);
    check5("bounce_level", level, 5'b00000);
    checkn("bounce_rise_count", rise_cnt[2] - base_r, 0);
    checkn("bounce_fall_count", fall_cnt[2] - base_f, 0);

    // Auto-repeat on channel 1: accept, then repeats at rcnt=10,13,...,28
    base_r = rise_cnt[1];
    base_f = fall_cnt[1];
    raw_in = 5'b00010;
    clk_wait(2);
    tick_wait(4);
    check5("rep_accept_rise", rise, 5'b00010);
    tick_wait(9);
    check5("rep_rcnt9_rise", rise, 5'b00000);
    tick_wait(1);
    check5("rep_rcnt10_rise", rise, 5'b00010);
    tick_wait(2);
    check5("rep_rcnt12_rise", rise, 5'b00000);
    tick_wait(1);
    check5("rep_rcnt13_rise", rise, 5'b00010);
    tick_wait(15);
    check5("rep_rcnt28_rise", rise, 5'b00010);
    check5("rep_hold_fall",   fall, 5'b00000);
    raw_in = 5'b00000;
    clk_wait(2);
    tick_wait(3);
    check5("rep_rel_pre_level", level, 5'b00010);
    tick_wait(1);
    check5("rep_rel_fall", fall, 5'b00010);
    clk_wait(2);
    checkn("rep_rise_count", rise_cnt[1] - base_r, 8);
    checkn("rep_fall_count", fall_cnt[1] - base_f, 1);

    // Masked channel 3: one rise only
    base_r = rise_cnt[3];
    base_f = fall_cnt[3];
    raw_in = 5'b01000;
    clk_wait(2);
    tick_wait(4);
    check5("mask_accept_rise", rise, 5'b01000);
    tick_wait(30);
    check5("mask_hold_level", level, 5'b01000);
    raw_in = 5'b00000;
    clk_wait(2);
    tick_wait(4);
    check5("mask_rel_fall", fall, 5'b01000);
    clk_wait(2);
    checkn("mask_rise_count", rise_cnt[3] - base_r, 1);
    checkn("mask_fall_count", fall_cnt[3] - base_f, 1);

    // Simultaneous edges on channels 4 and 0
    raw_in = 5'b10001;
    clk_wait(2);
    tick_wait(3);
    check5("simul_pre_level", level, 5'b00000);
    tick_wait(1);
    check5("simul_rise",  rise,  5'b10001);
    check5("simul_level", level, 5'b10001);
    raw_in = 5'b00000;
    clk_wait(2);
    tick_wait(4);
    check5("simul_fall", fall, 5'b10001);
    clk_wait(2);

    // Reset mid-repeat (ch1 in S_HI) and mid-debounce (ch0 at cnt=2)
    raw_in = 5'b00010;
    clk_wait(2);
    tick_wait(4);
    check5("rst_pre_level1", level, 5'b00010);
    raw_in = 5'b00011;
    clk_wait(2);
    tick_wait(2);
    rst = 1'b0;
    #1;
    check5("rst_async_level", level, 5'b00000);
    check5("rst_async_rise",  rise,  5'b00000);
    check5("rst_async_fall",  fall,  5'b00000);
    clk_wait(5);
    check5("rst_hold_level", level, 5'b00000);
    base_r = rise_cnt[0];
    rst = 1'b1;
    clk_wait(2);
    tick_wait(3);
    check5("rst_rel_pre_level", level, 5'b00000);
    tick_wait(1);
    check5("rst_rel_rise",  rise,  5'b00011);
    check5("rst_rel_level", level, 5'b00011);
    raw_in = 5'b00000;
    clk_wait(2);
    tick_wait(4);
    check5("rst_rel_fall", fall, 5'b00011);
    clk_wait(2);
    checkn("rst_rel_rise_count0", rise_cnt[0] - base_r, 1);

    checkn("pulse_shape_errors", bad_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
